// File: rtl/ysyx_23060171_lsu_pkg.sv
// Shared types and constants for the LSU stage.
//   lsu_state_e   : stage FSM states
//   LD_*          : load-type funct3 codes
//   STRB_*        : unshifted byte/half/word store strobes
//   is_misaligned : alignment check used when LSU_MISALIGN_TRAP_EN is defined
package ysyx_23060171_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } lsu_state_e;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // Stores are classified by strobe width, loads by funct3; unknown
    // load codes behave as lw.
    function automatic logic is_misaligned(input logic       we,
                                           input logic [2:0] mem_rd,
                                           input logic [3:0] wmask,
                                           input logic [1:0] off);
        if (we) begin
            if (wmask == STRB_W) return off != 2'b00;
            if (wmask == STRB_H) return off == 2'b11;
            return 1'b0;
        end
        case (mem_rd)
            LD_LB, LD_LBU: return 1'b0;
            LD_LH, LD_LHU: return off == 2'b11;
            default:       return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060171_load_ext.sv
// Load data lane select and sign/zero extension (combinational).
//   rdata  in  32  raw word from memory
//   off    in  2   address byte offset
//   mem_rd in  3   load funct3 (unknown codes behave as lw)
//   ext    out 32  extended load result
// Halfword lane is chosen by off[1] only, so an odd offset wraps to the
// containing half instead of straddling words.
module ysyx_23060171_load_ext
    import ysyx_23060171_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  mem_rd,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (mem_rd)
            LD_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  ext = {24'h0, byte_sel};
            LD_LH:   ext = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  ext = {16'h0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_23060171_lsu_stage.sv
// Memory stage between execute and writeback.
// Accepts one op per handshake (in_valid/in_ready), issues a load/store on a
// split request/response bus (mem_req_* / mem_resp_*), extends load data and
// presents it with the registered writeback bundle (out_valid/out_ready).
// Non-memory ops go straight to DONE one cycle after acceptance.
//   in_*       : op from execute (address, store data, mem controls, wb bundle)
//   out_*      : result to writeback (rdata, wb bundle, fault)
//   mem_req_*  : word-aligned request with shifted data and strobes
//   mem_resp_* : response; the stage is always ready for it
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned ops without bus
// traffic; otherwise they are issued with lane wrap and out_fault only
// reflects mem_resp_err.
module ysyx_23060171_lsu_stage
    import ysyx_23060171_lsu_pkg::*;
#(
    parameter int unsigned WB_W = 160
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_addr,
    input  logic [31:0]     in_wdata,
    input  logic            in_mem_valid,
    input  logic            in_mem_write,
    input  logic [2:0]      in_mem_rd,
    input  logic [7:0]      in_wmask,
    input  logic [WB_W-1:0] in_wb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_rdata,
    output logic [WB_W-1:0] out_wb,
    output logic            out_fault,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_req_we,
    output logic [31:0]     mem_req_addr,
    output logic [31:0]     mem_req_wdata,
    output logic [3:0]      mem_req_wstrb,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_rdata,
    input  logic            mem_resp_err
);

    lsu_state_e      state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            we_q, we_d;
    logic            fault_q, fault_d;
    logic [2:0]      mem_rd_q, mem_rd_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [WB_W-1:0] wb_q, wb_d;
    logic [31:0]     ext_data;
    logic            misaligned;
    logic            unused_wmask_hi;

    assign unused_wmask_hi = ^in_wmask[7:4];

    ysyx_23060171_load_ext u_load_ext (
        .rdata  (mem_resp_rdata),
        .off    (addr_q[1:0]),
        .mem_rd (mem_rd_q),
        .ext    (ext_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(in_mem_write, in_mem_rd, in_wmask[3:0], in_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = we_q;
        fault_d  = fault_q;
        mem_rd_d = mem_rd_q;
        wmask_d  = wmask_q;
        wb_d     = wb_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    we_d     = in_mem_valid & in_mem_write;
                    mem_rd_d = in_mem_rd;
                    wmask_d  = in_wmask[3:0];
                    wb_d     = in_wb;
                    rdata_d  = '0;
                    fault_d  = 1'b0;
                    if (!in_mem_valid) begin
                        state_d = S_DONE;
                    end else if (misaligned) begin
                        state_d = S_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) state_d = S_RESP;
            end
            S_RESP: begin
                if (mem_resp_valid) begin
                    rdata_d = we_q ? '0 : ext_data;
                    fault_d = mem_resp_err;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
            mem_rd_q <= '0;
            wmask_q  <= '0;
            wb_q     <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            fault_q  <= fault_d;
            mem_rd_q <= mem_rd_d;
            wmask_q  <= wmask_d;
            wb_q     <= wb_d;
        end
    end

    // All handshake and bus outputs decode directly from flops.
    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = {addr_q[31:2], 2'b00};
    assign mem_req_wdata = wdata_q << {addr_q[1:0], 3'b000};
    assign mem_req_wstrb = we_q ? (wmask_q << addr_q[1:0]) : 4'b0000;
    assign out_rdata     = rdata_q;
    assign out_wb        = wb_q;
    assign out_fault     = fault_q;

endmodule

// File: tb/tb_ysyx_23060171_lsu_stage.sv
module tb_ysyx_23060171_lsu_stage;

    localparam int unsigned WB_W = 160;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [31:0]     in_addr, in_wdata;
    logic            in_mem_valid, in_mem_write;
    logic [2:0]      in_mem_rd;
    logic [7:0]      in_wmask;
    logic [WB_W-1:0] in_wb;
    logic            out_valid, out_ready;
    logic [31:0]     out_rdata;
    logic [WB_W-1:0] out_wb;
    logic            out_fault;
    logic            mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]     mem_req_addr, mem_req_wdata;
    logic [3:0]      mem_req_wstrb;
    logic            mem_resp_valid;
    logic [31:0]     mem_resp_rdata;
    logic            mem_resp_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]     rdata;
        logic [WB_W-1:0] wb;
        logic            fault;
    } exp_t;

    typedef struct {
        logic            acc_ready;
        logic            saw_req;
        logic            we;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [3:0]      wstrb;
        logic            req_unstable;
        logic            out_unstable;
        logic            busy_ready;
        logic            timeout;
        int              latency;
        logic [31:0]     rdata;
        logic [WB_W-1:0] wb;
        logic            fault;
        logic            idle_after;
    } obs_t;

    exp_t exp_q[$];

    ysyx_23060171_lsu_stage #(.WB_W(WB_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_wdata       (in_wdata),
        .in_mem_valid   (in_mem_valid),
        .in_mem_write   (in_mem_write),
        .in_mem_rd      (in_mem_rd),
        .in_wmask       (in_wmask),
        .in_wb          (in_wb),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rdata      (out_rdata),
        .out_wb         (out_wb),
        .out_fault      (out_fault),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err)
    );

    always #5 clk = ~clk;

    // Drives one op through the stage acting as execute, memory and
    // writeback; only records what it observes.
    task automatic drive_op(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic memv, input logic we, input logic [2:0] rd,
                            input logic [7:0] wmask, input logic [WB_W-1:0] wb,
                            input logic [31:0] resp_rdata, input logic resp_err,
                            input int req_stall, input int out_stall, output obs_t o);
        int cyc;
        o = '{default: 0};
        o.acc_ready = in_ready;
        in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_mem_valid = memv;
        in_mem_write = we; in_mem_rd = rd; in_wmask = wmask; in_wb = wb;
        @(posedge clk); #1;
        in_valid = 1'b0; in_addr = $urandom(); in_wdata = $urandom(); in_wb = '1;
        in_mem_rd = 3'($urandom()); in_wmask = 8'($urandom());
        cyc = 1;
        while (!mem_req_valid && !out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        if (mem_req_valid) begin
            o.saw_req = 1'b1; o.we = mem_req_we; o.addr = mem_req_addr;
            o.wdata = mem_req_wdata; o.wstrb = mem_req_wstrb;
            if (in_ready !== 1'b0) o.busy_ready = 1'b1;
            for (int i = 0; i < req_stall; i++) begin
                @(posedge clk); #1; cyc++;
                if (mem_req_valid !== 1'b1 || mem_req_we !== o.we || mem_req_addr !== o.addr ||
                    mem_req_wdata !== o.wdata || mem_req_wstrb !== o.wstrb) o.req_unstable = 1'b1;
                if (in_ready !== 1'b0) o.busy_ready = 1'b1;
            end
            mem_req_ready = 1'b1;
            @(posedge clk); #1; cyc++;
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b1; mem_resp_rdata = resp_rdata; mem_resp_err = resp_err;
            @(posedge clk); #1; cyc++;
            mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_rdata = $urandom();
        end
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1; cyc++;
        end
        o.timeout = !out_valid; o.latency = cyc;
        o.rdata = out_rdata; o.wb = out_wb; o.fault = out_fault;
        for (int i = 0; i < out_stall; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_rdata !== o.rdata || out_wb !== o.wb ||
                out_fault !== o.fault || mem_req_valid !== 1'b0) o.out_unstable = 1'b1;
            if (in_ready !== 1'b0) o.busy_ready = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        o.idle_after = in_ready && !out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (out_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", out_rdata); end
        checks++; if (out_wb !== '0) begin failures++; $display("FAIL reset_wb got=%h exp=0", out_wb); end
        checks++; if (out_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", out_fault); end
    endtask

    task automatic test_nonmem();
        obs_t o; exp_t e;
        logic [WB_W-1:0] wb;
        wb = {4'h1, 148'h0, 8'hA5};
        exp_q.push_back('{rdata: 32'h0, wb: wb, fault: 1'b0});
        drive_op(32'h8000_0003, 32'hFFFF_FFFF, 1'b0, 1'b1, 3'b010, 8'hFF, wb, 32'h0, 1'b0, 0, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.timeout || o.latency != 1) begin failures++; $display("FAIL nonmem_latency got=%0d exp=1", o.latency); end
        checks++; if (o.saw_req !== 1'b0) begin failures++; $display("FAIL nonmem_no_req got=%b exp=0", o.saw_req); end
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL nonmem_rdata got=%h exp=%h", o.rdata, e.rdata); end
        checks++; if (o.wb !== e.wb) begin failures++; $display("FAIL nonmem_wb got=%h exp=%h", o.wb, e.wb); end
        checks++; if (o.fault !== e.fault) begin failures++; $display("FAIL nonmem_fault got=%b exp=%b", o.fault, e.fault); end
        checks++; if (o.idle_after !== 1'b1) begin failures++; $display("FAIL nonmem_idle got=%b exp=1", o.idle_after); end
    endtask

    task automatic test_load_ext();
        logic [31:0] taddr [8] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002,
                                   32'h8000_0010, 32'h8000_0000, 32'h8000_0004, 32'h8000_0001};
        logic [2:0]  trd   [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011, 3'b000};
        logic [31:0] tresp [8] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_1234, 32'h8001_1234,
                                   32'hCAFE_BABE, 32'h0000_7FFF, 32'h1234_5678, 32'h0000_7F00};
        logic [31:0] texp  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                                   32'hCAFE_BABE, 32'h0000_7FFF, 32'h1234_5678, 32'h0000_007F};
        obs_t o; exp_t e;
        logic [WB_W-1:0] wb;
        for (int i = 0; i < 8; i++) begin
            wb = {5{32'($urandom())}};
            exp_q.push_back('{rdata: texp[i], wb: wb, fault: 1'b0});
            drive_op(taddr[i], 32'hDEAD_BEEF, 1'b1, 1'b0, trd[i], 8'h0F, wb, tresp[i], 1'b0, 0, 0, o);
            e = exp_q.pop_front();
            checks++; if (o.timeout || o.latency != 3) begin failures++; $display("FAIL load%0d_latency got=%0d exp=3", i, o.latency); end
            checks++; if (o.saw_req !== 1'b1 || o.we !== 1'b0 || o.wstrb !== 4'b0000) begin failures++; $display("FAIL load%0d_req got=%b/%b/%b exp=1/0/0000", i, o.saw_req, o.we, o.wstrb); end
            checks++; if (o.addr !== {taddr[i][31:2], 2'b00}) begin failures++; $display("FAIL load%0d_addr got=%h exp=%h", i, o.addr, {taddr[i][31:2], 2'b00}); end
            checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL load%0d_rdata got=%h exp=%h", i, o.rdata, e.rdata); end
            checks++; if (o.wb !== e.wb || o.fault !== e.fault) begin failures++; $display("FAIL load%0d_wb_fault got=%h/%b exp=%h/%b", i, o.wb, o.fault, e.wb, e.fault); end
        end
    endtask

    task automatic test_store();
        logic [31:0] taddr [3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0004};
        logic [31:0] twd   [3] = '{32'h1234_ABCD, 32'h0000_00EE, 32'h0BAD_F00D};
        logic [7:0]  tmask [3] = '{8'h03, 8'hF1, 8'h0F};
        logic [31:0] eaddr [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004};
        logic [31:0] ewd   [3] = '{32'hABCD_0000, 32'h0000_EE00, 32'h0BAD_F00D};
        logic [3:0]  estrb [3] = '{4'b1100, 4'b0010, 4'b1111};
        obs_t o; exp_t e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{rdata: 32'h0, wb: {WB_W{1'b0}} | 160'(i + 7), fault: 1'b0});
            drive_op(taddr[i], twd[i], 1'b1, 1'b1, 3'b010, tmask[i], 160'(i + 7), 32'hFFFF_FFFF, 1'b0, 0, 0, o);
            e = exp_q.pop_front();
            checks++; if (o.saw_req !== 1'b1 || o.we !== 1'b1) begin failures++; $display("FAIL store%0d_req got=%b/%b exp=1/1", i, o.saw_req, o.we); end
            checks++; if (o.addr !== eaddr[i]) begin failures++; $display("FAIL store%0d_addr got=%h exp=%h", i, o.addr, eaddr[i]); end
            checks++; if (o.wdata !== ewd[i]) begin failures++; $display("FAIL store%0d_wdata got=%h exp=%h", i, o.wdata, ewd[i]); end
            checks++; if (o.wstrb !== estrb[i]) begin failures++; $display("FAIL store%0d_wstrb got=%b exp=%b", i, o.wstrb, estrb[i]); end
            checks++; if (o.rdata !== e.rdata || o.wb !== e.wb || o.fault !== e.fault) begin failures++; $display("FAIL store%0d_out got=%h/%h/%b exp=%h/%h/%b", i, o.rdata, o.wb, o.fault, e.rdata, e.wb, e.fault); end
        end
    endtask

    task automatic test_stall();
        obs_t o; exp_t e;
        exp_q.push_back('{rdata: 32'h5566_7788, wb: {WB_W{1'b1}} ^ 160'h3C, fault: 1'b0});
        drive_op(32'h8000_0020, 32'h0, 1'b1, 1'b0, 3'b010, 8'h0F, {WB_W{1'b1}} ^ 160'h3C, 32'h5566_7788, 1'b0, 5, 3, o);
        e = exp_q.pop_front();
        checks++; if (o.req_unstable !== 1'b0) begin failures++; $display("FAIL stall_req_stable got=%b exp=0", o.req_unstable); end
        checks++; if (o.out_unstable !== 1'b0) begin failures++; $display("FAIL stall_out_stable got=%b exp=0", o.out_unstable); end
        checks++; if (o.busy_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", o.busy_ready); end
        checks++; if (o.timeout || o.latency != 8) begin failures++; $display("FAIL stall_latency got=%0d exp=8", o.latency); end
        checks++; if (o.rdata !== e.rdata || o.wb !== e.wb) begin failures++; $display("FAIL stall_out got=%h/%h exp=%h/%h", o.rdata, o.wb, e.rdata, e.wb); end
    endtask

    task automatic test_misalign();
        logic [31:0] taddr [2] = '{32'h8000_0002, 32'h8000_0003};
        logic [2:0]  trd   [2] = '{3'b010, 3'b001};
        logic [31:0] tresp [2] = '{32'h1122_3344, 32'hBEEF_0000};
        logic [31:0] texp  [2] = '{32'h1122_3344, 32'hFFFF_BEEF};
        obs_t o; exp_t e;
        for (int i = 0; i < 2; i++) begin
`ifdef LSU_MISALIGN_TRAP_EN
            exp_q.push_back('{rdata: 32'h0, wb: 160'hAB, fault: 1'b1});
`else
            exp_q.push_back('{rdata: texp[i], wb: 160'hAB, fault: 1'b0});
`endif
            drive_op(taddr[i], 32'h0, 1'b1, 1'b0, trd[i], 8'h0F, 160'hAB, tresp[i], 1'b0, 0, 0, o);
            e = exp_q.pop_front();
`ifdef LSU_MISALIGN_TRAP_EN
            checks++; if (o.saw_req !== 1'b0 || o.latency != 1) begin failures++; $display("FAIL mis%0d_no_req got=%b/%0d exp=0/1", i, o.saw_req, o.latency); end
`else
            checks++; if (o.saw_req !== 1'b1 || o.addr !== 32'h8000_0000) begin failures++; $display("FAIL mis%0d_req got=%b/%h exp=1/80000000", i, o.saw_req, o.addr); end
`endif
            checks++; if (o.rdata !== e.rdata || o.fault !== e.fault) begin failures++; $display("FAIL mis%0d_out got=%h/%b exp=%h/%b", i, o.rdata, o.fault, e.rdata, e.fault); end
        end
    endtask

    task automatic test_bus_err();
        obs_t o; exp_t e;
        exp_q.push_back('{rdata: 32'h0000_0001, wb: 160'h77, fault: 1'b1});
        drive_op(32'h8000_0040, 32'h0, 1'b1, 1'b0, 3'b010, 8'h0F, 160'h77, 32'h0000_0001, 1'b1, 0, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.fault !== e.fault) begin failures++; $display("FAIL buserr_fault got=%b exp=%b", o.fault, e.fault); end
        exp_q.push_back('{rdata: 32'h0, wb: 160'h78, fault: 1'b0});
        drive_op(32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 8'h00, 160'h78, 32'h0, 1'b0, 0, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.fault !== e.fault) begin failures++; $display("FAIL buserr_clear got=%b exp=%b", o.fault, e.fault); end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e;
        logic [31:0] d [6];
        logic [WB_W-1:0] w [6];
        for (int i = 0; i < 6; i++) begin
            d[i] = $urandom(); w[i] = {5{32'($urandom())}};
            exp_q.push_back('{rdata: (i % 2 == 0) ? d[i] : 32'h0, wb: w[i], fault: 1'b0});
        end
        for (int i = 0; i < 6; i++) begin
            drive_op({$urandom_range(0, 1000), 2'b00}, 32'h0, (i % 2 == 0), 1'b0, 3'b010, 8'h0F,
                     w[i], d[i], 1'b0, i % 3, i % 2, o);
            if (exp_q.size() == 0) begin
                checks++; failures++; $display("FAIL b2b%0d_queue got=empty exp=entry", i);
            end else begin
                e = exp_q.pop_front();
                checks++; if (o.acc_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_in_ready got=%b exp=1", i, o.acc_ready); end
                checks++; if (o.timeout || o.rdata !== e.rdata || o.wb !== e.wb) begin failures++; $display("FAIL b2b%0d_out got=%h/%h exp=%h/%h", i, o.rdata, o.wb, e.rdata, e.wb); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        in_valid = 1'b1; in_addr = 32'h8000_0100; in_mem_valid = 1'b1; in_mem_write = 1'b0;
        in_mem_rd = 3'b010; in_wb = 160'hFEED; in_wmask = 8'h0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!mem_req_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL rstmid_req got=%b exp=1", mem_req_valid); end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_wb !== 160'hFEED) begin failures++; $display("FAIL rstmid_in_resp got=%b/%b/%h exp=0/0/feed", in_ready, out_valid, out_wb); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got=%b/%b/%b exp=1/0/0", in_ready, out_valid, mem_req_valid); end
        checks++; if (out_rdata !== 32'h0 || out_wb !== '0 || out_fault !== 1'b0) begin failures++; $display("FAIL rstmid_data got=%h/%h/%b exp=0/0/0", out_rdata, out_wb, out_fault); end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_quiet got=%b/%b exp=0/1", out_valid, in_ready); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_mem_valid = 1'b0;
        in_mem_write = 1'b0; in_mem_rd = '0; in_wmask = '0; in_wb = '0; out_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;
        test_reset();
        test_nonmem();
        test_load_ext();
        test_store();
        test_stall();
        test_misalign();
        test_bus_err();
        test_back_to_back();
        test_reset_mid();
        test_nonmem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
